// File: rtl/alu_pkg.sv
// Purpose: shared opcodes, flag bit positions, FSM encoding and op classification for alu_mc.
// Latency: none; the package holds declarations only.
// Backpressure: not applicable.
// Macro ALU_MC_DIV_EN makes DIVU/REMU multi-cycle. Without it they are undefined opcodes.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SRA  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_SLL  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    localparam int FLAG_EQ  = 5;
    localparam int FLAG_NE  = 4;
    localparam int FLAG_LT  = 3;
    localparam int FLAG_GE  = 2;
    localparam int FLAG_LTU = 1;
    localparam int FLAG_GEU = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Purpose: iterative shift-add multiplier that retires MUL_STEP multiplier bits per cycle.
// Latency: WIDTH/MUL_STEP cycles after the start cycle. done marks the cycle that retires the last bits.
// Backpressure: none. The caller must hold the result itself and must not restart the unit mid-run.
// Ports: clk, rst_n (async active-low); start, a, b load a new run.
//        done is high in the final step. product already includes the contribution of that step.
module alu_seq_mul #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CW    = $clog2(STEPS + 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] partial;

    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(STEPS);
        end else if (cnt_q != '0) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << MUL_STEP;
            mplier_d = mplier_q >> MUL_STEP;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // The next-state accumulator is exposed so the parent can register the product on the done edge.
    assign done    = (cnt_q == CW'(1));
    assign product = acc_d;

endmodule

// File: rtl/alu_mc.sv
// Purpose: multi-cycle execute ALU with a registered result and 6-bit branch flags.
// Latency: 1 cycle for single-cycle ops; WIDTH/MUL_STEP+1 for MUL; WIDTH+1 for DIVU/REMU.
// Backpressure: the result is held in DONE until out_ready. in_ready is combinational from out_ready only.
// Ports: in_valid/in_ready with src_a, src_b, alu_op; out_valid/out_ready with alu_result, flags, op_err.
// Macro ALU_MC_DIV_EN adds an inline restoring divider for DIVU/REMU.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1,
    parameter int SHW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [5:0]       flags,
    output logic             op_err
);

    localparam int            CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(WIDTH / MUL_STEP);

    logic [1:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [5:0]       flags_q, flags_d;
    logic             err_q, err_d;

    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_result;
    logic             sc_err;
    logic [5:0]       acc_flags;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             busy_last;
    logic [WIDTH-1:0] busy_result;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign shamt     = src_b[SHW-1:0];

    alu_seq_mul #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && (alu_op == OP_MUL)),
        .a       (src_a),
        .b       (src_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        acc_flags           = '0;
        acc_flags[FLAG_EQ]  = (src_a == src_b);
        acc_flags[FLAG_NE]  = (src_a != src_b);
        acc_flags[FLAG_LT]  = ($signed(src_a) < $signed(src_b));
        acc_flags[FLAG_GE]  = !($signed(src_a) < $signed(src_b));
        acc_flags[FLAG_LTU] = (src_a < src_b);
        acc_flags[FLAG_GEU] = !(src_a < src_b);
    end

    always_comb begin
        sc_result = '0;
        sc_err    = 1'b0;
        case (alu_op)
            OP_ADD:  sc_result = src_a + src_b;
            OP_SUB:  sc_result = src_a - src_b;
            OP_OR:   sc_result = src_a | src_b;
            OP_XOR:  sc_result = src_a ^ src_b;
            OP_AND:  sc_result = src_a & src_b;
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, acc_flags[FLAG_LT]};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, acc_flags[FLAG_LTU]};
            OP_SRA:  sc_result = $signed(src_a) >>> shamt;
            OP_SRL:  sc_result = src_a >> shamt;
            OP_SLL:  sc_result = src_a << shamt;
            OP_MUL:  sc_result = '0;
`ifdef ALU_MC_DIV_EN
            OP_DIVU, OP_REMU: sc_result = '0;
`endif
            default: sc_err = 1'b1;
        endcase
    end

`ifdef ALU_MC_DIV_EN
    // Restoring divider. quo starts as the dividend and shifts its bits into rem.
    // A zero divisor always passes the trial subtract, so the quotient is all ones
    // and the remainder is the dividend without any special case.
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d, quo_nx;
    logic [WIDTH-1:0] rem_q, rem_d, rem_nx;
    logic [WIDTH:0]   div_trial;

    always_comb begin
        div_trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        if (!div_trial[WIDTH]) begin
            rem_nx = div_trial[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_nx = {quo_q[WIDTH-2:0], 1'b0};
        end
        dvs_d = dvs_q;
        quo_d = quo_q;
        rem_d = rem_q;
        if (accept && is_multicycle(alu_op) && (alu_op != OP_MUL)) begin
            dvs_d = src_b;
            quo_d = src_a;
            rem_d = '0;
        end else if ((state_q == ST_BUSY) && (op_q != OP_MUL)) begin
            quo_d = quo_nx;
            rem_d = rem_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
        end else begin
            dvs_q <= dvs_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
        end
    end

    assign busy_result = (op_q == OP_MUL)  ? mul_product :
                         (op_q == OP_DIVU) ? quo_nx : rem_nx;
`else
    assign busy_result = mul_product;
`endif

    assign busy_last = (op_q == OP_MUL) ? mul_done : (cnt_q == CW'(1));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        case (state_q)
            ST_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (busy_last) begin
                    state_d  = ST_DONE;
                    result_d = busy_result;
                end
            end
            default: begin
                if (accept) begin
                    op_d    = alu_op;
                    flags_d = acc_flags;
                    if (is_multicycle(alu_op)) begin
                        state_d = ST_BUSY;
                        err_d   = 1'b0;
`ifdef ALU_MC_DIV_EN
                        cnt_d   = (alu_op == OP_MUL) ? MUL_CNT : CW'(WIDTH);
`else
                        cnt_d   = MUL_CNT;
`endif
                    end else begin
                        state_d  = ST_DONE;
                        result_d = sc_result;
                        err_d    = sc_err;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    assign alu_result = result_q;
    assign flags      = flags_q;
    assign op_err     = err_q;

endmodule

// File: tb/tb_alu_mc.sv
`timescale 1ns/1ps
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, op_err;
    logic [W-1:0] src_a, src_b, alu_result;
    logic [3:0]   alu_op;
    logic [5:0]   flags;

    logic         v4, r4, ov4, or4, e4;
    logic [W-1:0] a4, b4, res4;
    logic [3:0]   op4;
    logic [5:0]   f4;

    alu_mc #(.WIDTH(W), .MUL_STEP(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .src_a(src_a), .src_b(src_b), .alu_op(alu_op), .out_valid(out_valid),
        .out_ready(out_ready), .alu_result(alu_result), .flags(flags), .op_err(op_err)
    );

    alu_mc #(.WIDTH(W), .MUL_STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4),
        .src_a(a4), .src_b(b4), .alu_op(op4), .out_valid(ov4),
        .out_ready(or4), .alu_result(res4), .flags(f4), .op_err(e4)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, res;
        logic [5:0]   fl;
        logic         err;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic [5:0]   fl;
        logic         err;
        int           lat;
        int           acc_cyc;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    exp_t cur;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   head_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] mk_flags(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [5:0] f;
        f[5] = (a == b);
        f[4] = (a != b);
        f[3] = ($signed(a) < $signed(b));
        f[2] = ~f[3];
        f[1] = (a < b);
        f[0] = ~f[1];
        return f;
    endfunction

    function automatic void add(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic [5:0] fl, input logic err,
                                input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.fl = fl; v.err = err; v.lat = lat;
        tbl.push_back(v);
    endfunction

    // Scoreboard: expected entries are pushed when the handshake is seen and popped on output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    if (!head_seen) begin
                        chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
                        head_seen = 1;
                    end
                    if (out_ready) begin
                        chk("result", 64'(alu_result), 64'(sb[0].res));
                        chk("flags", 64'(flags), 64'(sb[0].fl));
                        chk("op_err", 64'(op_err), 64'(sb[0].err));
                        sb.delete(0);
                        head_seen = 0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                cur.acc_cyc = cyc;
                sb.push_back(cur);
            end
        end
    end

    // Called half a cycle after... precisely: called 1ns after a rising edge; returns 1ns after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res, input logic [5:0] fl, input logic err,
                        input int lat, output int waited);
        cur.res = res; cur.fl = fl; cur.err = err; cur.lat = lat; cur.acc_cyc = 0;
        alu_op = op; src_a = a; src_b = b; in_valid = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready && waited < 200);
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int bad;
        int k;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; src_a = '0; src_b = '0; alu_op = '0; out_ready = 1'b1;
        v4 = 1'b0; a4 = '0; b4 = '0; op4 = '0; or4 = 1'b1;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_result", 64'(alu_result), 64'(0));
        chk("rst_flags", 64'(flags), 64'(0));
        chk("rst_op_err", 64'(op_err), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst4_out_valid", 64'(ov4), 64'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        add(OP_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        6'b011001, 1'b0, 1);
        add(OP_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, 6'b011010, 1'b0, 1);
        add(OP_XOR,  32'hF0F0,     32'h0FF0,     32'hFF00,     6'b010101, 1'b0, 1);
        add(OP_SRA,  32'h80000000, 32'h24,       32'hF8000000, 6'b011001, 1'b0, 1);
        add(OP_SRL,  32'h80000000, 32'h24,       32'h08000000, 6'b011001, 1'b0, 1);
        add(OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        6'b011001, 1'b0, 1);
        add(OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        6'b011001, 1'b0, 1);
        add(OP_MUL,  32'h12345678, 32'h10,       32'h23456780, 6'b010101, 1'b0, 33);
        add(OP_OR,   32'h0F00,     32'h00F0,     32'h0FF0,     6'b010101, 1'b0, 1);
        add(OP_AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 6'b011001, 1'b0, 1);
        add(OP_SLL,  32'h1,        32'h3F,       32'h80000000, 6'b011010, 1'b0, 1);
        add(OP_ADD,  32'd7,        32'd7,        32'hE,        6'b100101, 1'b0, 1);
        add(4'd15,   32'hA,        32'hB,        32'h0,        6'b011010, 1'b1, 1);
        add(OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        6'b100101, 1'b0, 33);
        add(OP_SRA,  32'h7FFFFFF0, 32'h4,        32'h07FFFFFF, 6'b010101, 1'b0, 1);
`ifdef ALU_MC_DIV_EN
        add(OP_DIVU, 32'd100,      32'd7,        32'd14,       6'b010101, 1'b0, 33);
        add(OP_REMU, 32'd100,      32'd7,        32'd2,        6'b010101, 1'b0, 33);
        add(OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 6'b010101, 1'b0, 33);
        add(OP_REMU, 32'd5,        32'd0,        32'd5,        6'b010101, 1'b0, 33);
`else
        add(OP_DIVU, 32'd100,      32'd7,        32'd0,        6'b010101, 1'b1, 1);
        add(OP_REMU, 32'd100,      32'd7,        32'd0,        6'b010101, 1'b1, 1);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].fl, tbl[i].err, tbl[i].lat, w);
            if (i < 3) chk("b2b_in_ready_wait", 64'(w), 64'(1));
        end
        drain();

        // in_ready must stay low for every BUSY cycle of a MUL
        send(OP_MUL, 32'h12345678, 32'h10, 32'h23456780, 6'b010101, 1'b0, 33, w);
        bad = 0;
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        chk("busy_in_ready_low", 64'(bad), 64'(0));
        drain();

        for (int j = 0; j < 6; j++) begin
            ra = $urandom;
            rb = $urandom;
            send(OP_MUL, ra, rb, ra * rb, mk_flags(ra, rb), 1'b0, 33, w);
            send(OP_SUB, rb, ra, rb - ra, mk_flags(rb, ra), 1'b0, 1, w);
        end
        drain();

        // Output stall: result and flags hold, in_ready low, then same-edge accept on release
        out_ready = 1'b0;
        send(OP_ADD, 32'd2, 32'd3, 32'd5, 6'b011010, 1'b0, 1, w);
        bad = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || alu_result !== 32'd5 || flags !== 6'b011010 ||
                in_ready !== 1'b0 || op_err !== 1'b0) bad++;
        end
        chk("stall_hold", 64'(bad), 64'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(OP_SUB, 32'd9, 32'd4, 32'd5, 6'b010101, 1'b0, 1, w);
        chk("stall_release_same_edge", 64'(w), 64'(1));
        drain();

        // Asynchronous reset in the middle of a MUL
        send(OP_MUL, 32'd3, 32'd5, 32'd15, 6'b011010, 1'b0, 33, w);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_result", 64'(alu_result), 64'(0));
        chk("rst_mid_flags", 64'(flags), 64'(0));
        chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
        sb.delete();
        head_seen = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(OP_ADD, 32'd2, 32'd3, 32'd5, 6'b011010, 1'b0, 1, w);
        repeat (40) @(posedge clk);
        #1;
        drain();

        // MUL_STEP=4 instance: 8 steps, latency 9
        op4 = OP_MUL; a4 = 32'h12345678; b4 = 32'h10; v4 = 1'b1;
        @(negedge clk);
        chk("m4_in_ready", 64'(r4), 64'(1));
        @(posedge clk);
        #1 v4 = 1'b0;
        k = 0;
        bad = 0;
        do begin
            @(negedge clk);
            k++;
            if (!ov4 && r4) bad++;
        end while (!ov4 && k < 100);
        chk("m4_latency", 64'(k), 64'(9));
        chk("m4_busy_in_ready_low", 64'(bad), 64'(0));
        chk("m4_result", 64'(res4), 64'(32'h23456780));
        chk("m4_flags", 64'(f4), 64'(6'b010101));
        chk("m4_op_err", 64'(e4), 64'(0));

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
